// File: rtl/led_string_sequencer.sv
// Double-buffered LED string pattern generator feeding a START/LED/END word serializer.
// Optional LED_SEQ_BRIGHTNESS_EN scales each channel by brightness/256 on the output register.
`timescale 1ns/1ps
module led_string_sequencer #(
   parameter int unsigned NUM_PIXELS = 30,
   parameter int unsigned COLOR_W    = 8,
   parameter int unsigned GAP_W      = 16
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               enable,
   input  logic [1:0]         mode,
   input  logic [GAP_W-1:0]   frame_gap,
   input  logic [7:0]         brightness,
   input  logic               doled_busy,
   output logic               led_start,
   output logic [1:0]         input_type,
   output logic [COLOR_W-1:0] blue_out,
   output logic [COLOR_W-1:0] green_out,
   output logic [COLOR_W-1:0] red_out,
   output logic               frame_done
);

   localparam int unsigned IDX_W    = $clog2(NUM_PIXELS);
   localparam int unsigned PIX_W    = 3 * COLOR_W;
   localparam logic [7:0]  LAST_PIX = 8'(NUM_PIXELS - 1);

   typedef enum logic [1:0] {M_SOLID, M_CHASE, M_STRIPE, M_OFF} mode_t;
   typedef enum logic [1:0] {W_START, W_LED, W_END} word_t;
   typedef enum logic [3:0] {
      S_IDLE, S_SWAP, S_WAIT_START, S_SEND_START, S_WAIT_PIX, S_SEND_PIX,
      S_NEXT_PIX, S_WAIT_END, S_SEND_END, S_WAIT_DONE, S_GAP
   } state_t;

   state_t             state;
   logic [PIX_W-1:0]   bank [2][NUM_PIXELS];
   logic               front_sel;
   logic               back_ready;
   logic               gen_run;
   logic [7:0]         gen_idx;
   mode_t              gen_mode;
   logic [2:0]         color_idx;
   logic [2:0]         stripe_idx;
   logic [7:0]         pos;
   logic [PIX_W-1:0]   gen_pix;
   logic [PIX_W-1:0]   front_pix;
   logic [7:0]         snd_idx;
   logic [GAP_W-1:0]   gap_cnt;
   logic               swap;

   function automatic logic [PIX_W-1:0] palette(input logic [2:0] p);
      logic [2:0] bgr;
      case (p)
         3'd0:    bgr = 3'b100;
         3'd1:    bgr = 3'b010;
         3'd2:    bgr = 3'b001;
         3'd3:    bgr = 3'b110;
         3'd4:    bgr = 3'b101;
         3'd5:    bgr = 3'b011;
         3'd6:    bgr = 3'b111;
         default: bgr = 3'b000;
      endcase
      return {{COLOR_W{bgr[2]}}, {COLOR_W{bgr[1]}}, {COLOR_W{bgr[0]}}};
   endfunction

`ifdef LED_SEQ_BRIGHTNESS_EN
   function automatic logic [PIX_W-1:0] scale(input logic [PIX_W-1:0] px);
      logic [PIX_W-1:0]     res;
      logic [COLOR_W+7:0]   prod;
      res = '0;
      for (int unsigned c = 0; c < 3; c++) begin
         prod = (COLOR_W+8)'(px[c*COLOR_W +: COLOR_W]) * (COLOR_W+8)'(brightness);
         res[c*COLOR_W +: COLOR_W] = prod[COLOR_W+7:8];
      end
      return res;
   endfunction
`else
   logic unused_brightness;
   assign unused_brightness = ^brightness;

   function automatic logic [PIX_W-1:0] scale(input logic [PIX_W-1:0] px);
      return px;
   endfunction
`endif

   assign swap      = (state == S_SWAP);
   assign front_pix = bank[front_sel][snd_idx[IDX_W-1:0]];

   always_comb begin
      gen_pix = '0;
      case (gen_mode)
         M_SOLID:  gen_pix = palette(color_idx);
         M_CHASE:  if (gen_idx == pos) gen_pix = palette(color_idx);
         M_STRIPE: gen_pix = palette(stripe_idx);
         default:  gen_pix = '0;
      endcase
   end

   // Generator: one idle cycle after restart latches mode and seeds the stripe phase.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         back_ready <= 1'b0;
         gen_run    <= 1'b0;
         gen_idx    <= '0;
         gen_mode   <= M_SOLID;
         color_idx  <= '0;
         stripe_idx <= '0;
         pos        <= '0;
      end else if (swap) begin
         back_ready <= 1'b0;
         gen_run    <= 1'b0;
         gen_idx    <= '0;
      end else if (!gen_run && !back_ready) begin
         gen_mode   <= mode_t'(mode);
         stripe_idx <= color_idx;
         gen_idx    <= '0;
         gen_run    <= 1'b1;
      end else if (gen_run) begin
         stripe_idx <= (stripe_idx == 3'd6) ? 3'd0 : stripe_idx + 3'd1;
         if (gen_idx == LAST_PIX) begin
            gen_run    <= 1'b0;
            back_ready <= 1'b1;
            case (gen_mode)
               M_SOLID, M_STRIPE:
                  color_idx <= (color_idx == 3'd6) ? 3'd0 : color_idx + 3'd1;
               M_CHASE:
                  if (pos == LAST_PIX) begin
                     pos       <= '0;
                     color_idx <= (color_idx == 3'd6) ? 3'd0 : color_idx + 3'd1;
                  end else begin
                     pos <= pos + 8'd1;
                  end
               default: ;
            endcase
         end else begin
            gen_idx <= gen_idx + 8'd1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (gen_run) bank[~front_sel][gen_idx[IDX_W-1:0]] <= gen_pix;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= S_IDLE;
         front_sel  <= 1'b0;
         snd_idx    <= '0;
         gap_cnt    <= '0;
         led_start  <= 1'b0;
         input_type <= '0;
         blue_out   <= '0;
         green_out  <= '0;
         red_out    <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            S_IDLE: if (enable && back_ready) state <= S_SWAP;
            S_SWAP: begin
               front_sel <= ~front_sel;
               state     <= S_WAIT_START;
            end
            S_WAIT_START: if (!doled_busy) begin
               state      <= S_SEND_START;
               led_start  <= 1'b1;
               input_type <= W_START;
               {blue_out, green_out, red_out} <= '0;
            end
            S_SEND_START: if (doled_busy) begin
               led_start <= 1'b0;
               snd_idx   <= '0;
               state     <= S_WAIT_PIX;
            end
            S_WAIT_PIX: if (!doled_busy) begin
               state      <= S_SEND_PIX;
               led_start  <= 1'b1;
               input_type <= W_LED;
               {blue_out, green_out, red_out} <= scale(front_pix);
            end
            S_SEND_PIX: if (doled_busy) begin
               led_start <= 1'b0;
               state     <= S_NEXT_PIX;
            end
            S_NEXT_PIX: begin
               if (snd_idx == LAST_PIX) begin
                  state <= S_WAIT_END;
               end else begin
                  snd_idx <= snd_idx + 8'd1;
                  state   <= S_WAIT_PIX;
               end
            end
            S_WAIT_END: if (!doled_busy) begin
               state      <= S_SEND_END;
               led_start  <= 1'b1;
               input_type <= W_END;
               {blue_out, green_out, red_out} <= '0;
            end
            S_SEND_END: if (doled_busy) begin
               led_start <= 1'b0;
               state     <= S_WAIT_DONE;
            end
            S_WAIT_DONE: if (!doled_busy) begin
               frame_done <= 1'b1;
               gap_cnt    <= '0;
               state      <= S_GAP;
            end
            S_GAP: begin
               if (gap_cnt == frame_gap) state <= S_IDLE;
               else gap_cnt <= gap_cnt + GAP_W'(1);
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
